// File: rtl/alu_seq_if.sv
// alu_seq_if: groups the request/response signals of alu_seq.
//   master : drives start, Operation, A, B; observes ALUOut, Hi, Zero, busy, done
//   slave  : the ALU side (inverse directions)
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       Operation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] ALUOut;
  logic [WIDTH-1:0] Hi;
  logic             Zero;
  logic             busy;
  logic             done;

  modport master (
    output start, Operation, A, B,
    input  ALUOut, Hi, Zero, busy, done
  );

  modport slave (
    input  start, Operation, A, B,
    output ALUOut, Hi, Zero, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle execute-stage ALU.
//   Single-cycle ops (AND, OR, ADD, SUB, SLTU, NOR) write ALUOut on the
//   accepting edge; MULU (shift-add) and DIVU (restoring) take WIDTH cycles
//   and write {Hi, ALUOut}. done pulses for one cycle after every update.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high, clears all state
//   bus   : alu_seq_if slave (start, Operation, A, B -> ALUOut, Hi, Zero,
//           busy, done)
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor
  logic [2*WIDTH-1:0] work_q, work_d;     // {acc, multiplier} or {rem, dividend/quotient}
  logic [WIDTH-1:0]   alu_q, alu_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] iter_next;
  logic               last_iter;
  logic [WIDTH-1:0]   single_res;

  // One iteration of each algorithm, computed from the working registers.
  // Both leave the high half in Hi and the low half in ALUOut at the end.
  always_comb begin
    // Shift-add: add multiplicand to the upper half when the current
    // multiplier LSB is set, then shift the whole product right by one.
    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} +
                (work_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, work_q[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder,
    // subtract when it fits; the quotient bit enters at the LSB.
    div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_next  = {div_rem, work_q[WIDTH-2:0], div_ge};

    iter_next = (state_q == S_DIV) ? div_next : mul_next;
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    case (bus.Operation)
      OP_AND:  single_res = bus.A & bus.B;
      OP_OR:   single_res = bus.A | bus.B;
      OP_ADD:  single_res = bus.A + bus.B;
      OP_SUB:  single_res = bus.A - bus.B;
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OP_NOR:  single_res = ~(bus.A | bus.B);
      default: single_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    work_d  = work_q;
    alu_d   = alu_q;
    hi_d    = hi_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.Operation == OP_MULU) begin
            state_d = S_MUL;
            cnt_d   = '0;
            opnd_d  = bus.A;
            work_d  = {{WIDTH{1'b0}}, bus.B};
          end else if (bus.Operation == OP_DIVU) begin
            state_d = S_DIV;
            cnt_d   = '0;
            opnd_d  = bus.B;
            work_d  = {{WIDTH{1'b0}}, bus.A};
          end else begin
            alu_d  = single_res;
            done_d = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        work_d = iter_next;
        cnt_d  = cnt_q + 1'b1;
        if (last_iter) begin
          // The final iteration feeds the result registers directly, so the
          // outputs never show partial values.
          state_d = S_IDLE;
          cnt_d   = '0;
          alu_d   = iter_next[WIDTH-1:0];
          hi_d    = iter_next[2*WIDTH-1:WIDTH];
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      work_q  <= '0;
      alu_q   <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      work_q  <= work_d;
      alu_q   <= alu_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
    end
  end

  assign bus.ALUOut = alu_q;
  assign bus.Hi     = hi_q;
  assign bus.Zero   = (alu_q == '0);
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH = 32 (dut32, index 0)
// and WIDTH = 8 (dut8, index 1). A timing model predicts busy/done and pushes
// expected results on acceptance; the monitor pops them on done.
module tb_alu_seq;

  typedef struct packed {
    logic        iter;
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_s [2];
  logic [3:0]  op_s    [2];
  logic [31:0] a_s     [2];
  logic [31:0] b_s     [2];
  logic [31:0] alu_s   [2];
  logic [31:0] hi_s    [2];
  logic        zero_s  [2];
  logic        busy_s  [2];
  logic        done_s  [2];

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  int          rem      [2];
  logic        exp_done [2];
  logic [31:0] mlo      [2];
  logic [31:0] mhi      [2];
  exp_t        sb0 [$];
  exp_t        sb1 [$];

  alu_seq_if #(.WIDTH(32)) bus32 ();
  alu_seq_if #(.WIDTH(8))  bus8  ();

  alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  assign bus32.start     = start_s[0];
  assign bus32.Operation = op_s[0];
  assign bus32.A         = a_s[0];
  assign bus32.B         = b_s[0];
  assign alu_s[0]        = bus32.ALUOut;
  assign hi_s[0]         = bus32.Hi;
  assign zero_s[0]       = bus32.Zero;
  assign busy_s[0]       = bus32.busy;
  assign done_s[0]       = bus32.done;

  assign bus8.start      = start_s[1];
  assign bus8.Operation  = op_s[1];
  assign bus8.A          = a_s[1][7:0];
  assign bus8.B          = b_s[1][7:0];
  assign alu_s[1]        = {24'h0, bus8.ALUOut};
  assign hi_s[1]         = {24'h0, bus8.Hi};
  assign zero_s[1]       = bus8.Zero;
  assign busy_s[1]       = bus8.busy;
  assign done_s[1]       = bus8.done;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] m;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    exp_t e;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    a = a_in & m;
    b = b_in & m;
    e = '0;
    case (op)
      4'b0000: e.lo = a & b;
      4'b0001: e.lo = a | b;
      4'b0010: e.lo = (a + b) & m;
      4'b0110: e.lo = (a - b) & m;
      4'b0111: e.lo = (a < b) ? 32'd1 : 32'd0;
      4'b1100: e.lo = ~(a | b) & m;
      4'b1000: begin
        e.iter = 1'b1;
        p = {32'h0, a} * {32'h0, b};
        e.lo = p[31:0] & m;
        e.hi = 32'(p >> w) & m;
      end
      4'b1001: begin
        e.iter = 1'b1;
        if (b == 32'h0) begin
          e.lo = m;
          e.hi = a;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
      default: e.lo = 32'h0;
    endcase
    return e;
  endfunction

  // Timing/acceptance model: acceptance only when the model itself is idle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        rem[i]      <= 0;
        exp_done[i] <= 1'b0;
      end
      sb0.delete();
      sb1.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp_done[i] <= 1'b0;
        if (rem[i] > 0) begin
          rem[i] <= rem[i] - 1;
          if (rem[i] == 1) exp_done[i] <= 1'b1;
        end else if (start_s[i]) begin
          exp_t e;
          e = model((i == 0) ? 32 : 8, op_s[i], a_s[i], b_s[i]);
          if (i == 0) sb0.push_back(e);
          else        sb1.push_back(e);
          if (e.iter) rem[i] <= (i == 0) ? 32 : 8;
          else        exp_done[i] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          mlo[i] = 32'h0;
          mhi[i] = 32'h0;
        end
        check($sformatf("d%0d_busy", i), busy_s[i], rem[i] != 0);
        check($sformatf("d%0d_done", i), done_s[i], exp_done[i]);
        if (done_s[i]) begin
          have = 1'b0;
          if (i == 0 && sb0.size() > 0) begin
            e = sb0.pop_front();
            have = 1'b1;
          end else if (i == 1 && sb1.size() > 0) begin
            e = sb1.pop_front();
            have = 1'b1;
          end
          check($sformatf("d%0d_sb_nonempty", i), have, 1'b1);
          if (have) begin
            mlo[i] = e.lo;
            if (e.iter) mhi[i] = e.hi;
          end
        end
        check($sformatf("d%0d_aluout", i), alu_s[i], mlo[i]);
        check($sformatf("d%0d_hi", i), hi_s[i], mhi[i]);
        check($sformatf("d%0d_zero", i), zero_s[i], mlo[i] == 32'h0);
      end
    end
  end

  // Directed op on dut32: returns after the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] elo, input logic [31:0] ehi, input int elat);
    int n;
    bit seen;
    @(posedge clk); #2;
    start_s[0] = 1'b1; op_s[0] = op; a_s[0] = a; b_s[0] = b;
    @(posedge clk); #2;
    start_s[0] = 1'b0; a_s[0] = $urandom; b_s[0] = $urandom;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (done_s[0]) seen = 1'b1;
      else n++;
    end
    check({tag, "_latency"}, n, elat);
    check({tag, "_lo"}, alu_s[0], elo);
    check({tag, "_hi"}, hi_s[0], ehi);
    check({tag, "_zero"}, zero_s[0], elo == 32'h0);
    check({tag, "_busy"}, busy_s[0], 1'b0);
  endtask

  function automatic logic [3:0] pick_op();
    case ($urandom_range(0, 8))
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0110;
      4: return 4'b0111;
      5: return 4'b1100;
      6: return 4'b1000;
      7: return 4'b1001;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; op_s[i] = 4'h0; a_s[i] = 32'h0; b_s[i] = 32'h0;
    end
    @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_aluout", alu_s[0], 32'h0);
    check("rst_hi", hi_s[0], 32'h0);
    check("rst_zero", zero_s[0], 1'b1);
    check("rst_busy", busy_s[0], 1'b0);
    check("rst_done", done_s[0], 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;

    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 0);
    run_op("sub", 4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 32'h0, 0);
    run_op("sltu", 4'b0111, 32'd3, 32'h8000_0000, 32'h1, 32'h0, 0);
    run_op("nor", 4'b1100, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 0);
    run_op("undef", 4'b1111, 32'h1234, 32'h5678, 32'h0, 32'h0, 0);
    run_op("mulu_max", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 32);
    run_op("divu", 4'b1001, 32'd100, 32'd7, 32'd14, 32'd2, 32);
    run_op("divu_by0", 4'b1001, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 32);

    // MULU 3*5 with stray starts while busy, then an ADD in the done cycle.
    @(posedge clk); #2;
    start_s[0] = 1'b1; op_s[0] = 4'b1000; a_s[0] = 32'd3; b_s[0] = 32'd5;
    for (int j = 0; j <= 32; j++) begin
      @(posedge clk); #2;
      start_s[0] = (j == 2 || j == 10 || j == 32);
      op_s[0] = 4'b0010; a_s[0] = 32'd1; b_s[0] = 32'd1;
      @(negedge clk);
      check($sformatf("ign_done_c%0d", j), done_s[0], j == 32);
    end
    check("ign_mul_lo", alu_s[0], 32'd15);
    check("ign_mul_hi", hi_s[0], 32'd0);
    @(posedge clk); #2;
    start_s[0] = 1'b0;
    @(negedge clk);
    check("b2b_add_done", done_s[0], 1'b1);
    check("b2b_add_lo", alu_s[0], 32'd2);

    // Reset 10 cycles into a DIVU.
    run_op("divu_pre", 4'b1001, 32'd100, 32'd7, 32'd14, 32'd2, 32);
    @(posedge clk); #2;
    start_s[0] = 1'b1; op_s[0] = 4'b1001; a_s[0] = 32'd1000; b_s[0] = 32'd3;
    @(posedge clk); #2;
    start_s[0] = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_aluout", alu_s[0], 32'h0);
    check("midrst_hi", hi_s[0], 32'h0);
    check("midrst_zero", zero_s[0], 1'b1);
    check("midrst_busy", busy_s[0], 1'b0);
    check("midrst_done", done_s[0], 1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      check("postrst_no_done", done_s[0], 1'b0);
    end
    run_op("mulu_6x7", 4'b1000, 32'd6, 32'd7, 32'd42, 32'd0, 32);

    // Random regression on both widths; bursts with start held high.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      reset = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < 2; i++) begin
        start_s[i] = ((c % 400) < 150) ? 1'b1 : ($urandom_range(0, 2) != 0);
        op_s[i]    = pick_op();
        a_s[i]     = pick_val();
        b_s[i]     = pick_val();
      end
    end
    @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) start_s[i] = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("sb0_drained", sb0.size(), 0);
    check("sb1_drained", sb1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
